vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with sync, blanking and frame pulse registered alongside the counters (0-clk skew); free-running, no backpressure.
// Define VGA_CLK_DIV_EN to derive a 1-in-4 pixel tick from clk; otherwise clk itself is the pixel clock.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

`ifdef VGA_CLK_DIV_EN
    logic [1:0] prescale_q;

    // Tick is high while the prescaler sits at 3, so the 4th edge after reset is the first advancing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prescale_q <= 2'd0;
        else     prescale_q <= prescale_q + 2'd1;
    end

    assign pixel_tick = (prescale_q == 2'd3);
`else
    logic run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= 1'b1;
    end

    assign pixel_tick = run_q;
`endif

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       fs_d;
    logic       hsync_q, vsync_q, video_q, fs_q;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fs_d = 1'b0;
        if (pixel_tick) begin
            if (x_q == H_MAX) begin
                x_d = 10'd0;
                if (y_q == V_MAX) begin
                    y_d  = 10'd0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Decodes only refresh on tick edges so the first pixel after reset stays blanked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= fs_d;
            if (pixel_tick) begin
                x_q     <= x_d;
                y_q     <= y_d;
                hsync_q <= ~((x_d >= HS_START) && (x_d < HS_END));
                vsync_q <= ~((y_d >= VS_START) && (y_d < VS_END));
                video_q <= (x_d < H_VIS) && (y_d < V_VIS);
            end
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default horizontal timing with a shortened frame (7 lines) so full frames fit in a short run.
module tb_vga_sync_gen;
    localparam int HT = 800;
    localparam int VT = 7;
`ifdef VGA_CLK_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pixel_tick;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, hsync, vsync, frame_start;

    vga_sync_gen #(
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .pixel_tick(pixel_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, exp_o;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    int   cur_t = 0;

    // Pixel ticks completed after n clk edges since reset release.
    function automatic int ticks_of(input int edges);
        if (DIV) return edges / 4;
        return (edges > 0) ? edges - 1 : 0;
    endfunction

    function automatic obs_t model(input int edges);
        obs_t e;
        int   tt;
        bit   fresh;
        tt = ticks_of(edges);
        if (DIV) begin
            e.tick = ((edges + 1) % 4 == 0);
            fresh  = (edges > 0) && (edges % 4 == 0);
        end else begin
            e.tick = (edges > 0);
            fresh  = (edges >= 2);
        end
        e.x   = 10'(tt % HT);
        e.y   = 10'((tt / HT) % VT);
        e.hs  = !(e.x >= 10'd656 && e.x < 10'd752);
        e.vs  = !(e.y >= 10'd4 && e.y < 10'd6);
        e.von = (tt > 0) && (e.x < 10'd640) && (e.y < 10'd3);
        e.fs  = fresh && (e.x == 10'd0) && (e.y == 10'd0);
        return e;
    endfunction

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic check_obs(input string name, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s at %0t: got tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b, want tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b",
                     name, $time, g.tick, g.x, g.y, g.von, g.hs, g.vs, g.fs,
                     e.tick, e.x, e.y, e.von, e.hs, e.vs, e.fs);
        end
    endtask

    task automatic check_int(input string name, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, g, e);
        end
    endtask

    // Stimulus side: every clk edge yields one expected observation.
    always @(posedge clk) begin
        #1;
        if (rst) n = 0;
        else     n = n + 1;
        cur_t = ticks_of(n);
        exp_q.push_back(model(n));
    end

    logic [9:0] prev_x = '0, prev_y = '0;
    bit         prev_hs = 1'b1, prev_fs = 1'b0;
    int         hs_cnt = 0, vs_lines = 0, pix_cnt = 0;

    // Monitor: pops the scoreboard each cycle and runs per-line / per-frame directed checks.
    always @(negedge clk) begin
        got = {pixel_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start};
        if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            check_obs("cycle", got, exp_o);
        end
        if (rst) begin
            prev_x = '0; prev_y = '0; prev_hs = 1'b1; prev_fs = 1'b0;
            hs_cnt = 0; vs_lines = 0; pix_cnt = 0;
        end else begin
            if (pixel_x != prev_x || pixel_y != prev_y) begin
                pix_cnt++;
                if (!hsync) begin
                    hs_cnt++;
                    if (prev_hs) check_int("hsync_start_x", int'(pixel_x), 656);
                end
                if (pixel_x == 10'd0) begin
                    check_int("hsync_width", hs_cnt, 96);
                    check_int("y_step", int'(pixel_y), (int'(prev_y) + 1) % VT);
                    hs_cnt = 0;
                    if (!vsync) vs_lines++;
                    if (pixel_y == 10'd0) begin
                        check_int("vsync_lines", vs_lines, 2);
                        vs_lines = 0;
                    end
                end
                if (pixel_x == 10'd639 && pixel_y == 10'd2) check_int("video_639_2", int'(video_on), 1);
                if (pixel_x == 10'd640 && pixel_y == 10'd2) check_int("video_640_2", int'(video_on), 0);
                if (pixel_x == 10'd0   && pixel_y == 10'd3) check_int("video_0_3", int'(video_on), 0);
                prev_hs = hsync;
            end
            if (frame_start) begin
                check_int("frame_start_gap", pix_cnt, HT * VT);
                check_int("frame_start_width", int'(prev_fs), 0);
                pix_cnt = 0;
            end
            prev_fs = frame_start;
            prev_x  = pixel_x;
            prev_y  = pixel_y;
        end
        if (errors >= 40) finish_run();
    end

    initial begin
        int budget;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Two full frames, then stop mid-line at (700,2) of the third frame.
        budget = 0;
        while (cur_t != 13500 && budget < 80000) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (cur_t != 13500) begin
            check_int("reach_mid_frame_timeout", cur_t, 13500);
            finish_run();
        end
        check_int("pre_rst_x", int'(pixel_x), 700);
        check_int("pre_rst_y", int'(pixel_y), 2);

        rst = 1'b1;
        #1;
        check_obs("async_rst", {pixel_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start},
                  model(0));
        exp_q.delete();
        exp_q.push_back(model(0));
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        budget = 0;
        while (cur_t < 1000 && budget < 8000) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (cur_t < 1000) check_int("resume_timeout", cur_t, 1000);
        repeat (2) @(negedge clk);
        #1;
        finish_run();
    end

endmodule
